// File: rtl/gb_video_pkg.sv
// Shared definitions for the video block: PPU mode codes, DMA register
// offset, DMA controller state type and the echo-RAM source fold.
package gb_video_pkg;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam logic [3:0] ADDR_DMA = 4'h6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } dma_state_t;

  // Sources at $E0xx and above are echo RAM and alias $C0xx upward.
  function automatic logic [7:0] echo_fold(input logic [7:0] hi);
    if (hi >= 8'hE0) begin
      return hi - 8'h20;
    end else begin
      return hi;
    end
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer and OAM write-port arbiter between the DMA engine and
// the CPU, with CPU access further gated by the PPU mode.
module oam_dma_ctrl
  import gb_video_pkg::*;
#(
  parameter int BYTES        = 160,
  parameter int CYC_PER_BYTE = 4,
  parameter int START_DELAY  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel_dma,
  input  logic        cpu_sel_oam,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic [1:0]  mode,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_di,
  input  logic [7:0]  oam_do,
  output logic        dma_active,
  output logic        dma_bus_busy
);

  localparam int PW = (CYC_PER_BYTE > 1) ? $clog2(CYC_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CYC_PER_BYTE - 1);
  localparam logic [PW-1:0] PHASE_WR   = PW'(2);
  localparam logic [DW-1:0] DELAY_LOAD = DW'(START_DELAY - 1);
  localparam logic [7:0]    BYTE_LAST  = 8'(BYTES - 1);

  dma_state_t      state;
  dma_state_t      state_next;
  logic [DW-1:0]   delay_cnt;
  logic [PW-1:0]   phase;
  logic [7:0]      byte_idx;
  logic [7:0]      dma_reg;
  logic [7:0]      src_hi;
  logic            dma_wr;
  logic            cpu_ok;

  assign dma_wr   = cpu_sel_dma && cpu_wr;
  assign dma_addr = {echo_fold(src_hi), byte_idx};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-derived bus ownership flags.
  always_comb begin
    state_next   = state;
    dma_active   = 1'b0;
    dma_bus_busy = 1'b0;
    dma_rd       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dma_wr) begin
          state_next = ST_START;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_START: begin
        dma_bus_busy = 1'b1;
        if (dma_wr) begin
          state_next = ST_START;
        end else if (delay_cnt == {DW{1'b0}}) begin
          state_next = ST_XFER;
        end else begin
          state_next = ST_START;
        end
      end
      ST_XFER: begin
        dma_bus_busy = 1'b1;
        dma_active   = 1'b1;
        dma_rd       = 1'b1;
        if (dma_wr) begin
          state_next = ST_START;
        end else if ((phase == PHASE_LAST) && (byte_idx == BYTE_LAST)) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_XFER;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Start delay, per-byte phase and byte index; a $FF46 write restarts all three.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delay_cnt <= {DW{1'b0}};
      phase     <= {PW{1'b0}};
      byte_idx  <= 8'h00;
    end else if (dma_wr) begin
      delay_cnt <= DELAY_LOAD;
      phase     <= {PW{1'b0}};
      byte_idx  <= 8'h00;
    end else begin
      case (state)
        ST_START: begin
          if (delay_cnt != {DW{1'b0}}) begin
            delay_cnt <= delay_cnt - DW'(1);
          end else begin
            phase    <= {PW{1'b0}};
            byte_idx <= 8'h00;
          end
        end
        ST_XFER: begin
          if (phase == PHASE_LAST) begin
            phase    <= {PW{1'b0}};
            byte_idx <= byte_idx + 8'd1;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          delay_cnt <= delay_cnt;
          phase     <= phase;
          byte_idx  <= byte_idx;
        end
      endcase
    end
  end

  // $FF46 register and latched source page.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_reg <= 8'h00;
      src_hi  <= 8'h00;
    end else if (dma_wr) begin
      dma_reg <= cpu_di;
      src_hi  <= cpu_di;
    end else begin
      dma_reg <= dma_reg;
      src_hi  <= src_hi;
    end
  end

  // OAM port mux and CPU read data; DMA owns the port outright during XFER.
  always_comb begin
    cpu_ok = (state != ST_XFER) && ((mode == MODE_HBLANK) || (mode == MODE_VBLANK));
    if (state == ST_XFER) begin
      oam_addr = byte_idx;
      oam_di   = dma_data;
      oam_wr   = (phase == PHASE_WR);
    end else begin
      oam_addr = cpu_addr;
      oam_di   = cpu_di;
      oam_wr   = cpu_ok && cpu_wr && cpu_sel_oam;
    end
    if (cpu_sel_oam) begin
      if (cpu_ok) begin
        cpu_do = oam_do;
      end else begin
        cpu_do = 8'hFF;
      end
    end else if (cpu_sel_dma) begin
      cpu_do = dma_reg;
    end else begin
      cpu_do = 8'hFF;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: vector table for the CPU/OAM mux,
// randomized CPU traffic against a timing-arithmetic transfer model.
module tb_oam_dma_ctrl;

  localparam int BYTES    = 160;
  localparam int CPB      = 4;
  localparam int SD       = 4;
  localparam int XFER_END = SD + BYTES * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_sel_dma, cpu_sel_oam, cpu_wr;
  logic [7:0]  cpu_addr, cpu_di, cpu_do;
  logic [1:0]  mode;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data;
  logic        oam_wr;
  logic [7:0]  oam_addr, oam_di, oam_do;
  logic        dma_active, dma_bus_busy;

  logic [7:0]  oam_mem [256];
  logic        init_oam;
  logic [7:0]  m_oam [256];
  logic [7:0]  m_reg;
  int          total = 0;
  int          bad = 0;
  int          dma_pulses = 0;

  typedef struct {
    logic       sd;
    logic       so;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] di;
    logic [1:0] md;
    logic [7:0] e_do;
    logic       e_wr;
  } vec_t;
  vec_t tbl [13];

  oam_dma_ctrl #(.BYTES(BYTES), .CYC_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset),
    .cpu_sel_dma(cpu_sel_dma), .cpu_sel_oam(cpu_sel_oam), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do), .mode(mode),
    .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_data(dma_data),
    .oam_wr(oam_wr), .oam_addr(oam_addr), .oam_di(oam_di), .oam_do(oam_do),
    .dma_active(dma_active), .dma_bus_busy(dma_bus_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return (a[7:0] * 8'd5) ^ a[15:8] ^ 8'h5A;
  endfunction

  assign dma_data = src_byte(dma_addr);
  assign oam_do   = oam_mem[oam_addr];

  always @(posedge clk) begin
    if (init_oam) begin
      for (int i = 0; i < 256; i++) oam_mem[i] <= 8'(i) ^ 8'hA5;
    end else if (oam_wr) begin
      oam_mem[oam_addr] <= oam_di;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_sel_dma = 1'b0;
    cpu_sel_oam = 1'b0;
    cpu_wr      = 1'b0;
    cpu_addr    = 8'h00;
    cpu_di      = 8'h00;
  endtask

  function automatic logic [7:0] exp_do(input logic sd, input logic so, input logic [7:0] a,
                                        input logic [1:0] md, input logic act);
    if (so) return (!act && md < 2'd2) ? m_oam[a] : 8'hFF;
    else if (sd) return m_reg;
    else return 8'hFF;
  endfunction

  task automatic check_oam(input string name);
    for (int i = 0; i < 256; i++) check(name, 32'(oam_mem[i]), 32'(m_oam[i]));
  endtask

  task automatic check_reg(input logic [7:0] exp);
    cpu_sel_dma = 1'b1;
    #1;
    check("ff46_read", 32'(cpu_do), 32'(exp));
    cpu_sel_dma = 1'b0;
  endtask

  // Issue a $FF46 write, then follow stop_k cycles against the timing model.
  task automatic run_xfer(input logic [7:0] hi, input int stop_k, input bit rnd, input logic [1:0] fmd);
    logic [7:0] eff, ea, ed;
    logic       act, busy, ewr;
    int         t, b, p;
    cpu_sel_dma = 1'b1; cpu_wr = 1'b1; cpu_di = hi; cpu_sel_oam = 1'b0; mode = fmd;
    step();
    m_reg = hi;
    eff = (hi >= 8'hE0) ? hi - 8'h20 : hi;
    for (int k = 0; k < stop_k; k++) begin
      cpu_sel_dma = 1'b0;
      if (rnd) begin
        mode        = 2'($urandom_range(3, 0));
        cpu_sel_oam = 1'($urandom_range(1, 0));
        cpu_wr      = ($urandom_range(3, 0) == 0);
        cpu_addr    = 8'($urandom);
        cpu_di      = 8'($urandom);
      end else begin
        mode = fmd; cpu_sel_oam = 1'b0; cpu_wr = 1'b0;
      end
      busy = (k < XFER_END);
      act  = (k >= SD) && (k < XFER_END);
      t = k - SD; b = (t >= 0) ? t / CPB : 0; p = (t >= 0) ? t % CPB : 0;
      if (act) begin
        ewr = (p == 2); ea = 8'(b); ed = src_byte({eff, 8'(b)});
      end else begin
        ewr = cpu_sel_oam && cpu_wr && (mode < 2'd2); ea = cpu_addr; ed = cpu_di;
      end
      #1;
      check("ctl", 32'({busy, act, act, ewr, (act ? {eff, 8'(b)} : 16'h0000)}),
            32'({dma_bus_busy, dma_active, dma_rd, oam_wr, (dma_active ? dma_addr : 16'h0000)}));
      if (ewr) check("oam_port", 32'({ea, ed}), 32'({oam_addr, oam_di}));
      check("cpu_do", 32'(cpu_do), 32'(exp_do(1'b0, cpu_sel_oam, cpu_addr, mode, act)));
      if (act && oam_wr) dma_pulses++;
      if (ewr) m_oam[ea] = ed;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    //           sd    so    wr    addr   di     md    e_do   e_wr
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 2'd0, 8'hB5, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 2'd2, 8'hFF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 2'd3, 8'hFF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 2'd1, 8'hB5, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h3C, 2'd2, 8'hFF, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 2'd0, 8'h85, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h20, 8'h3C, 2'd0, 8'h85, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 2'd1, 8'h3C, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h46, 8'h00, 2'd3, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 2'd0, 8'hFF, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 2'd0, 8'hB5, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 2'd3, 8'hFF, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h30, 8'h77, 2'd0, 8'hFF, 1'b0};

    idle_inputs();
    mode = 2'd0; reset = 1'b1; init_oam = 1'b1; m_reg = 8'h00;
    for (int i = 0; i < 256; i++) m_oam[i] = 8'(i) ^ 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", 32'({dma_active, dma_bus_busy, dma_rd, oam_wr}), 32'h0);
    check("rst_dma_addr", 32'(dma_addr), 32'h0);
    check_reg(8'h00);
    reset = 1'b0; init_oam = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      cpu_sel_dma = tbl[i].sd; cpu_sel_oam = tbl[i].so; cpu_wr = tbl[i].wr;
      cpu_addr = tbl[i].addr; cpu_di = tbl[i].di; mode = tbl[i].md;
      #1;
      check("tbl_do", 32'(cpu_do), 32'(tbl[i].e_do));
      check("tbl_wr", 32'(oam_wr), 32'(tbl[i].e_wr));
      if (tbl[i].e_wr) check("tbl_port", 32'({oam_addr, oam_di}), 32'({tbl[i].addr, tbl[i].di}));
      step();
    end
    idle_inputs();
    m_oam[8'h20] = 8'h3C;

    // Random CPU traffic with the DMA idle.
    for (int i = 0; i < 60; i++) begin
      mode        = 2'($urandom_range(3, 0));
      cpu_sel_oam = 1'($urandom_range(1, 0));
      cpu_sel_dma = 1'($urandom_range(1, 0));
      cpu_wr      = cpu_sel_dma ? 1'b0 : 1'($urandom_range(1, 0));
      cpu_addr    = 8'($urandom);
      cpu_di      = 8'($urandom);
      #1;
      check("idle_do", 32'(cpu_do), 32'(exp_do(cpu_sel_dma, cpu_sel_oam, cpu_addr, mode, 1'b0)));
      check("idle_wr", 32'(oam_wr), 32'(cpu_sel_oam && cpu_wr && mode < 2'd2));
      if (cpu_sel_oam && cpu_wr && mode < 2'd2) m_oam[cpu_addr] = cpu_di;
      step();
    end
    idle_inputs();

    dma_pulses = 0;
    run_xfer(8'hC0, XFER_END + 16, 1'b0, 2'd1);
    check("pulses_c0", 32'(dma_pulses), 32'(BYTES));
    check_oam("oam_c0");
    check_reg(8'hC0);

    dma_pulses = 0;
    run_xfer(8'hFE, XFER_END + 16, 1'b1, 2'd0);
    check("pulses_fe", 32'(dma_pulses), 32'(BYTES));
    check_oam("oam_fe");
    check_reg(8'hFE);

    dma_pulses = 0;
    run_xfer(8'($urandom_range(255, 0)), XFER_END + 16, 1'b1, 2'd0);
    check("pulses_rnd", 32'(dma_pulses), 32'(BYTES));
    check_oam("oam_rnd");

    // Restart after 50 bytes: second transfer runs a full length from its own write.
    dma_pulses = 0;
    run_xfer(8'hC0, SD + 50 * CPB, 1'b0, 2'd1);
    check("pulses_part", 32'(dma_pulses), 32'(50));
    run_xfer(8'hC1, XFER_END + 16, 1'b0, 2'd1);
    check("pulses_restart", 32'(dma_pulses), 32'(50 + BYTES));
    check_oam("oam_restart");
    check_reg(8'hC1);

    // Asynchronous reset at byte 80.
    run_xfer(8'hC2, SD + 80 * CPB, 1'b1, 2'd0);
    mode = 2'd0;
    reset = 1'b1;
    #1;
    check("arst_flags", 32'({dma_active, dma_bus_busy, dma_rd, oam_wr}), 32'h0);
    check_reg(8'h00);
    m_reg = 8'h00;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      check("post_rst", 32'({dma_active, dma_bus_busy, oam_wr}), 32'h0);
    end
    check_oam("oam_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
